fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer for the RV core front end. Owns the 64-bit fetch PC,

---
 rtl/fetch_ctrl.sv | 162 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues one aligned imem request
// at a time and hands 32-bit words to decode as single-cycle pulses.
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter logic [31:0] NOP_INST   = 32'h00000013,
  parameter logic [31:0] COUNT_INIT = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [63:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic        imem_rvalid_i,
  input  logic [63:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_out_o,
  output logic [63:0] inst_pc_o,
  output logic [31:0] inst_count_o,
  output logic [1:0]  state_o
);

  // Handshake: a request is outstanding while imem_req_o=1 and completes on the
  // cycle imem_ack_i=1; exactly one imem_rvalid_i pulse follows each accepted request.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [63:0] addr_q, addr_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_out_q, inst_out_d;
  logic [63:0] inst_pc_q, inst_pc_d;
  logic [31:0] count_q, count_d;
  logic        discard_q, discard_d;
  logic [31:0] hold_q, hold_d;

  logic [31:0] word;
  logic [63:0] redir_pc;
  logic        deliver;
  logic [31:0] deliver_word;

  assign word     = pc_q[2] ? imem_rdata_i[63:32] : imem_rdata_i[31:0];
  assign redir_pc = {redirect_pc_i[63:2], 2'b00};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    inst_valid_d = 1'b0;
    inst_out_d   = NOP_INST;
    inst_pc_d    = inst_pc_q;
    count_d      = count_q;
    discard_d    = discard_q;
    hold_d       = hold_q;
    deliver      = 1'b0;
    deliver_word = hold_q;

    case (state_q)
      IDLE: begin
        if (redirect_valid_i) pc_d = redir_pc;
        state_d = REQ;
      end
      REQ: begin
        // A redirect cannot retract the pending request; its response is dropped instead.
        if (redirect_valid_i) begin
          pc_d      = redir_pc;
          discard_d = 1'b1;
        end
        if (imem_ack_i) state_d = WAIT;
      end
      WAIT: begin
        if (redirect_valid_i) begin
          pc_d = redir_pc;
          if (imem_rvalid_i) begin
            discard_d = 1'b0;
            state_d   = REQ;
          end else begin
            discard_d = 1'b1;
          end
        end else if (imem_rvalid_i) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = REQ;
          end else if (stall_i) begin
            hold_d  = word;
            state_d = HOLD;
          end else begin
            deliver      = 1'b1;
            deliver_word = word;
          end
        end
      end
      HOLD: begin
        if (redirect_valid_i) begin
          pc_d    = redir_pc;
          hold_d  = 32'h0;
          state_d = REQ;
        end else if (!stall_i) begin
          deliver      = 1'b1;
          deliver_word = hold_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (deliver) begin
      inst_valid_d = 1'b1;
      inst_out_d   = deliver_word;
      inst_pc_d    = pc_q;
      pc_d         = pc_q + 64'd4;
      count_d      = count_q + 32'd1;
      state_d      = REQ;
    end

    // The address is captured on entry to REQ and held until the ack.
    req_d = (state_d == REQ);
    if (state_d == REQ && state_q != REQ) addr_d = {pc_d[63:3], 3'b000};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      req_q        <= 1'b0;
      addr_q       <= 64'h0;
      inst_valid_q <= 1'b0;
      inst_out_q   <= NOP_INST;
      inst_pc_q    <= 64'h0;
      count_q      <= COUNT_INIT;
      discard_q    <= 1'b0;
      hold_q       <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      inst_valid_q <= inst_valid_d;
      inst_out_q   <= inst_out_d;
      inst_pc_q    <= inst_pc_d;
      count_q      <= count_d;
      discard_q    <= discard_d;
      hold_q       <= hold_d;
    end
  end

  assign imem_req_o   = req_q;
  assign imem_addr_o  = addr_q;
  assign inst_valid_o = inst_valid_q;
  assign inst_out_o   = inst_out_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_count_o = count_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a default instance for the main scenarios and a
// second instance with PC/count near their wrap points.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        imem_ack = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [63:0] imem_rdata = 64'h0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [63:0] inst_pc;
  logic [31:0] inst_count;
  logic [1:0]  state;

  logic        ack_w = 1'b0;
  logic        rvalid_w = 1'b0;
  logic [63:0] rdata_w = 64'h0;
  logic        req_w;
  logic [63:0] addr_w;
  logic        valid_w;
  logic [31:0] out_w;
  logic [63:0] pc_w;
  logic [31:0] count_w;
  logic [1:0]  state_w;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .stall_i(stall),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_ack_i(imem_ack),
    .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .inst_valid_o(inst_valid), .inst_out_o(inst_out), .inst_pc_o(inst_pc),
    .inst_count_o(inst_count), .state_o(state)
  );

  fetch_ctrl #(
    .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC),
    .COUNT_INIT(32'hFFFF_FFFF)
  ) dut_w (
    .clk(clk), .rst(rst), .stall_i(1'b0),
    .redirect_valid_i(1'b0), .redirect_pc_i(64'h0),
    .imem_req_o(req_w), .imem_addr_o(addr_w), .imem_ack_i(ack_w),
    .imem_rvalid_i(rvalid_w), .imem_rdata_i(rdata_w),
    .inst_valid_o(valid_w), .inst_out_o(out_w), .inst_pc_o(pc_w),
    .inst_count_o(count_w), .state_o(state_w)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_cycle();
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
  endtask

  task automatic rvalid_cycle(input logic [63:0] data);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    step();
    imem_rvalid = 1'b0;
  endtask

  task automatic check_pulse(input string tag, input logic [31:0] inst,
                             input logic [63:0] pc, input logic [31:0] cnt);
    check({tag, "_valid"}, {63'h0, inst_valid}, 64'h1);
    check({tag, "_inst"},  {32'h0, inst_out}, {32'h0, inst});
    check({tag, "_pc"},    inst_pc, pc);
    check({tag, "_count"}, {32'h0, inst_count}, {32'h0, cnt});
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    step();
    step();
    check("rst_req",   {63'h0, imem_req}, 64'h0);
    check("rst_addr",  imem_addr, 64'h0);
    check("rst_valid", {63'h0, inst_valid}, 64'h0);
    check("rst_inst",  {32'h0, inst_out}, 64'h13);
    check("rst_pc",    inst_pc, 64'h0);
    check("rst_count", {32'h0, inst_count}, 64'h0);
    check("rst_state", {62'h0, state}, 64'h0);
    check("rst_w_count", {32'h0, count_w}, 64'hFFFF_FFFF);

    // 1: back-to-back fetches from one doubleword
    rst = 1'b0;
    step();
    check("t1_req0",  {63'h0, imem_req}, 64'h1);
    check("t1_addr0", imem_addr, 64'h0);
    ack_cycle();
    check("t1_req_drop", {63'h0, imem_req}, 64'h0);
    rvalid_cycle(64'h00500093_00100093);
    check_pulse("t1_a", 32'h00100093, 64'h0, 32'd1);
    check("t1_req1",  {63'h0, imem_req}, 64'h1);
    check("t1_addr1", imem_addr, 64'h0);
    ack_cycle();
    check("t1_pulse_end", {63'h0, inst_valid}, 64'h0);
    check("t1_nop", {32'h0, inst_out}, 64'h13);
    rvalid_cycle(64'h00500093_00100093);
    check_pulse("t1_b", 32'h00500093, 64'h4, 32'd2);
    check("t1_addr2", imem_addr, 64'h8);

    // 2: decode stall for three cycles around the response
    ack_cycle();
    stall = 1'b1;
    rvalid_cycle(64'hAAAA0001_BBBB0002);
    for (int i = 0; i < 3; i++) begin
      check("t2_stall_valid", {63'h0, inst_valid}, 64'h0);
      check("t2_stall_inst",  {32'h0, inst_out}, 64'h13);
      if (i < 2) step();
    end
    check("t2_hold_state", {62'h0, state}, 64'h3);
    stall = 1'b0;
    step();
    check_pulse("t2", 32'hBBBB0002, 64'h8, 32'd3);
    check("t2_addr", imem_addr, 64'h8);

    // 3: redirect while waiting, stale response arrives two cycles later
    ack_cycle();
    redirect_valid = 1'b1;
    redirect_pc = 64'h1002;
    step();
    redirect_valid = 1'b0;
    step();
    rvalid_cycle(64'hDEAD0000_DEAD0004);
    check("t3_drop_valid", {63'h0, inst_valid}, 64'h0);
    check("t3_req",  {63'h0, imem_req}, 64'h1);
    check("t3_addr", imem_addr, 64'h1000);
    ack_cycle();
    rvalid_cycle(64'h11111111_22222222);
    check_pulse("t3", 32'h22222222, 64'h1000, 32'd4);

    // 4: redirect coincides with response and stall
    ack_cycle();
    imem_rvalid = 1'b1;
    imem_rdata = 64'hCAFE0000_CAFE0001;
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'h2000;
    step();
    imem_rvalid = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    check("t4_valid", {63'h0, inst_valid}, 64'h0);
    check("t4_state", {62'h0, state}, 64'h1);
    check("t4_addr",  imem_addr, 64'h2000);
    check("t4_count", {32'h0, inst_count}, 64'd4);
    ack_cycle();
    rvalid_cycle(64'h33333333_44444444);
    check_pulse("t4", 32'h44444444, 64'h2000, 32'd5);

    // 5: ack held off five cycles, redirect in the second
    for (int i = 0; i < 5; i++) begin
      redirect_valid = (i == 1);
      redirect_pc = 64'h3000;
      step();
      check("t5_req_held",  {63'h0, imem_req}, 64'h1);
      check("t5_addr_held", imem_addr, 64'h2000);
    end
    redirect_valid = 1'b0;
    ack_cycle();
    rvalid_cycle(64'h99999999_99999999);
    check("t5_drop_valid", {63'h0, inst_valid}, 64'h0);
    check("t5_addr_new", imem_addr, 64'h3000);
    ack_cycle();
    rvalid_cycle(64'h55555555_66666666);
    check_pulse("t5", 32'h66666666, 64'h3000, 32'd6);

    // 6: PC and counter wrap on the second instance; reset mid-request on the first
    rst = 1'b1;
    step();
    step();
    check("t6_rst_count", {32'h0, inst_count}, 64'h0);
    check("t6_rst_req",   {63'h0, imem_req}, 64'h0);
    rst = 1'b0;
    step();
    check("t6_w_addr", addr_w, 64'hFFFF_FFFF_FFFF_FFF8);
    ack_w = 1'b1;
    step();
    ack_w = 1'b0;
    rvalid_w = 1'b1;
    rdata_w = 64'h77777777_88888888;
    step();
    rvalid_w = 1'b0;
    check("t6_w_valid", {63'h0, valid_w}, 64'h1);
    check("t6_w_inst",  {32'h0, out_w}, 64'h77777777);
    check("t6_w_pc",    pc_w, 64'hFFFF_FFFF_FFFF_FFFC);
    check("t6_w_count", {32'h0, count_w}, 64'h0);
    check("t6_w_addr_wrap", addr_w, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
